cart_mem_arbiter: RTL and testbench



---
 rtl/cart_mem_pkg.sv | 17 +
 rtl/cart_mem_req_latch.sv | 54 +++++
 rtl/cart_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared definitions for the cartridge memory arbiter: FSM encoding,
// requester indices and the data returned by an aborted read.
package cart_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] PORT_S0 = 2'd0;
    localparam logic [1:0] PORT_S1 = 2'd1;
    localparam logic [1:0] PORT_LD = 2'd2;

    localparam logic [7:0] ABORT_DATA = 8'hFF;

endpackage

// File: rtl/cart_mem_req_latch.sv
// Per-requester pending register. Holds one outstanding request; a strobe
// while busy is dropped and flagged. The clear input is the requester's
// completion pulse, so a strobe in that same cycle is accepted as new work.
module cart_mem_req_latch #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_din,
    input  logic              i_clr,
    output logic              o_pending,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_din,
    output logic              o_is_wr,
    output logic              o_overrun
);

    logic              r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din;
    logic              r_is_wr;
    logic              w_strobe;
    logic              w_accept;

    assign w_strobe  = i_rd | i_wr;
    assign w_accept  = w_strobe & (~r_pending | i_clr);
    assign o_overrun = w_strobe & r_pending & ~i_clr;

    // Capture a new request, or drop the pending flag on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_addr    <= {ADDR_W{1'b0}};
            r_din     <= 8'h00;
            r_is_wr   <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_addr    <= i_addr;
            r_din     <= i_din;
            r_is_wr   <= i_wr;
        end else if (i_clr) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_din     = r_din;
    assign o_is_wr   = r_is_wr;

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares one cartridge memory port between two slot mappers and the ROM
// loader. Loader wins outright; the slots alternate. One transaction is in
// flight at a time and is aborted with 8'hFF data if memory never answers.
module cart_mem_arbiter
    import cart_mem_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic              s0_rd,
    input  logic              s0_wr,
    input  logic [7:0]        s0_din,
    output logic [7:0]        s0_dout,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic              s1_rd,
    input  logic              s1_wr,
    input  logic [7:0]        s1_din,
    output logic [7:0]        s1_dout,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_wr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready,
    output logic              overrun,
    output logic              timeout
);

    // Last wait-counter value before the transaction is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic              w_s0_pend, w_s1_pend, w_ld_pend;
    logic [ADDR_W-1:0] w_s0_addr, w_s1_addr, w_ld_addr;
    logic [7:0]        w_s0_din, w_s1_din, w_ld_din;
    logic              w_s0_is_wr, w_s1_is_wr, w_ld_is_wr;
    logic              w_s0_ovr, w_s1_ovr, w_ld_ovr;
    logic              w_s0_elig, w_s1_elig, w_ld_elig;

    logic              w_sel_valid;
    logic [1:0]        w_sel_port;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_din;
    logic              w_sel_wr;
    logic              w_done;
    logic              w_abort;
    logic [7:0]        w_done_data;

    state_t            r_state;
    logic [1:0]        r_port;
    logic              r_is_wr;
    logic              r_rr;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_din;
    logic              r_mem_rd, r_mem_wr;
    logic              r_s0_ready, r_s1_ready, r_ld_ack;
    logic [7:0]        r_s0_dout, r_s1_dout;
    logic              r_overrun, r_timeout;

    cart_mem_req_latch #(.ADDR_W(ADDR_W)) u_s0_req (
        .clk(clk), .reset(reset), .i_rd(s0_rd), .i_wr(s0_wr), .i_addr(s0_addr),
        .i_din(s0_din), .i_clr(r_s0_ready), .o_pending(w_s0_pend), .o_addr(w_s0_addr),
        .o_din(w_s0_din), .o_is_wr(w_s0_is_wr), .o_overrun(w_s0_ovr)
    );

    cart_mem_req_latch #(.ADDR_W(ADDR_W)) u_s1_req (
        .clk(clk), .reset(reset), .i_rd(s1_rd), .i_wr(s1_wr), .i_addr(s1_addr),
        .i_din(s1_din), .i_clr(r_s1_ready), .o_pending(w_s1_pend), .o_addr(w_s1_addr),
        .o_din(w_s1_din), .o_is_wr(w_s1_is_wr), .o_overrun(w_s1_ovr)
    );

    cart_mem_req_latch #(.ADDR_W(ADDR_W)) u_ld_req (
        .clk(clk), .reset(reset), .i_rd(1'b0), .i_wr(ld_wr), .i_addr(ld_addr),
        .i_din(ld_data), .i_clr(r_ld_ack), .o_pending(w_ld_pend), .o_addr(w_ld_addr),
        .o_din(w_ld_din), .o_is_wr(w_ld_is_wr), .o_overrun(w_ld_ovr)
    );

    // A request whose completion pulse is showing is already served.
    assign w_s0_elig = w_s0_pend & ~r_s0_ready;
    assign w_s1_elig = w_s1_pend & ~r_s1_ready;
    assign w_ld_elig = w_ld_pend & ~r_ld_ack;

    // Pick the next requester: loader first, then alternate between slots.
    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_port  = PORT_LD;
        if (w_ld_elig) begin
            w_sel_port = PORT_LD;
        end else if (w_s0_elig && w_s1_elig) begin
            w_sel_port = r_rr ? PORT_S1 : PORT_S0;
        end else if (w_s0_elig) begin
            w_sel_port = PORT_S0;
        end else if (w_s1_elig) begin
            w_sel_port = PORT_S1;
        end else begin
            w_sel_valid = 1'b0;
        end
    end

    // Route the chosen requester's pending request toward the memory port.
    always_comb begin
        w_sel_addr = w_ld_addr;
        w_sel_din  = w_ld_din;
        w_sel_wr   = w_ld_is_wr;
        case (w_sel_port)
            PORT_S0: begin
                w_sel_addr = w_s0_addr;
                w_sel_din  = w_s0_din;
                w_sel_wr   = w_s0_is_wr;
            end
            PORT_S1: begin
                w_sel_addr = w_s1_addr;
                w_sel_din  = w_s1_din;
                w_sel_wr   = w_s1_is_wr;
            end
            default: begin
                w_sel_addr = w_ld_addr;
                w_sel_din  = w_ld_din;
                w_sel_wr   = w_ld_is_wr;
            end
        endcase
    end

    // Decide whether the transaction in flight finishes now, and with what data.
    always_comb begin
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_done_data = mem_dout;
        if (r_state == ST_WAIT) begin
            if (mem_ready) begin
                w_done      = 1'b1;
                w_done_data = mem_dout;
            end else if (r_cnt == TO_LAST) begin
                w_done      = 1'b1;
                w_abort     = 1'b1;
                w_done_data = ABORT_DATA;
            end else begin
                w_done = 1'b0;
            end
        end else begin
            w_done = 1'b0;
        end
    end

    // Arbiter FSM: select, issue a one-cycle command, wait for completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_port     <= PORT_S0;
            r_is_wr    <= 1'b0;
            r_rr       <= 1'b0;
            r_cnt      <= 8'd0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_mem_din  <= 8'h00;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_s0_ready <= 1'b0;
            r_s1_ready <= 1'b0;
            r_ld_ack   <= 1'b0;
            r_s0_dout  <= 8'h00;
            r_s1_dout  <= 8'h00;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_s0_ready <= 1'b0;
            r_s1_ready <= 1'b0;
            r_ld_ack   <= 1'b0;
            if (w_s0_ovr || w_s1_ovr || w_ld_ovr) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_port     <= w_sel_port;
                        r_is_wr    <= w_sel_wr;
                        r_mem_addr <= w_sel_addr;
                        r_mem_din  <= w_sel_din;
                        r_mem_rd   <= ~w_sel_wr;
                        r_mem_wr   <= w_sel_wr;
                        if (w_sel_port == PORT_S0) begin
                            r_rr <= 1'b1;
                        end else if (w_sel_port == PORT_S1) begin
                            r_rr <= 1'b0;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= 8'd0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        if (w_abort) begin
                            r_timeout <= 1'b1;
                        end
                        case (r_port)
                            PORT_S0: begin
                                r_s0_ready <= 1'b1;
                                if (!r_is_wr) begin
                                    r_s0_dout <= w_done_data;
                                end
                            end
                            PORT_S1: begin
                                r_s1_ready <= 1'b1;
                                if (!r_is_wr) begin
                                    r_s1_dout <= w_done_data;
                                end
                            end
                            default: r_ld_ack <= 1'b1;
                        endcase
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_rd   = r_mem_rd;
    assign mem_wr   = r_mem_wr;
    assign s0_ready = r_s0_ready;
    assign s1_ready = r_s1_ready;
    assign ld_ack   = r_ld_ack;
    assign s0_dout  = r_s0_dout;
    assign s1_dout  = r_s1_dout;
    assign overrun  = r_overrun;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: a timestamp-based request model is
// checked against every output each cycle, and each scenario also pins a few
// hand-derived results (grant order, latency, returned data).
module tb_cart_mem_arbiter;

    localparam int ADDR_W  = 25;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] s0_addr = '0, s1_addr = '0, ld_addr = '0;
    logic              s0_rd = 1'b0, s0_wr = 1'b0, s1_rd = 1'b0, s1_wr = 1'b0, ld_wr = 1'b0;
    logic [7:0]        s0_din = 8'h00, s1_din = 8'h00, ld_data = 8'h00;
    logic [7:0]        s0_dout, s1_dout, mem_din;
    logic              s0_ready, s1_ready, ld_ack, mem_rd, mem_wr, overrun, timeout;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_dout = 8'h33;
    logic              mem_ready = 1'b0;

    cart_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .s0_addr(s0_addr), .s0_rd(s0_rd), .s0_wr(s0_wr), .s0_din(s0_din),
        .s0_dout(s0_dout), .s0_ready(s0_ready),
        .s1_addr(s1_addr), .s1_rd(s1_rd), .s1_wr(s1_wr), .s1_din(s1_din),
        .s1_dout(s1_dout), .s1_ready(s1_ready),
        .ld_addr(ld_addr), .ld_wr(ld_wr), .ld_data(ld_data), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_ready(mem_ready),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory responder
    int          lat = 2;
    bit          resp_en = 1'b1;
    int          resp_cnt = 0;
    logic [24:0] resp_addr = '0;

    // observation log
    logic [24:0] cmd_addr[$];
    logic [7:0]  cmd_din[$];
    bit          cmd_wr[$];
    int          cmd_cyc[$];
    int          rdy_cnt[3];
    int          rdy_cyc[3];

    // model state (index 0 = slot 0, 1 = slot 1, 2 = loader)
    bit          m_pend[3];
    logic [24:0] m_addr[3];
    logic [7:0]  m_data[3];
    bit          m_wr[3];
    bit          m_busy = 1'b0;
    int          m_cur = 0;
    bit          m_cur_wr = 1'b0;
    int          m_wait_start = 0;
    bit          m_rr = 1'b0;
    bit          e_rdy[3];
    logic [7:0]  e_dout[2];
    bit          e_mem_rd = 1'b0, e_mem_wr = 1'b0, e_ovr = 1'b0, e_to = 1'b0;
    logic [24:0] e_mem_addr = '0;
    logic [7:0]  e_mem_din = 8'h00;

    function automatic logic [7:0] mem_val(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h1A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Advance the model across the cycle that just ended (number cyc).
    task automatic model_step();
        bit          rn[3];
        bit          srd[3];
        bit          swr[3];
        logic [24:0] sa[3];
        logic [7:0]  sd[3];
        bit          done;
        bit          was_busy;
        logic [7:0]  dval;
        int          win;
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                m_pend[p] = 1'b0;
                e_rdy[p]  = 1'b0;
            end
            e_dout[0] = 8'h00; e_dout[1] = 8'h00;
            e_mem_rd = 1'b0; e_mem_wr = 1'b0; e_mem_addr = '0; e_mem_din = 8'h00;
            e_ovr = 1'b0; e_to = 1'b0; m_busy = 1'b0; m_rr = 1'b0;
            return;
        end
        srd = '{s0_rd, s1_rd, 1'b0};
        swr = '{s0_wr, s1_wr, ld_wr};
        sa  = '{s0_addr, s1_addr, ld_addr};
        sd  = '{s0_din, s1_din, ld_data};
        rn  = e_rdy;
        for (int p = 0; p < 3; p++) e_rdy[p] = 1'b0;
        e_mem_rd = 1'b0;
        e_mem_wr = 1'b0;
        was_busy = m_busy;
        done = 1'b0;
        dval = 8'h00;
        if (m_busy && cyc >= m_wait_start) begin
            if (mem_ready) begin
                done = 1'b1; dval = mem_dout;
            end else if (cyc == m_wait_start + TIMEOUT - 1) begin
                done = 1'b1; dval = 8'hFF; e_to = 1'b1;
            end
        end
        if (done) begin
            e_rdy[m_cur] = 1'b1;
            if (!m_cur_wr && m_cur < 2) e_dout[m_cur] = dval;
            m_busy = 1'b0;
        end
        if (!was_busy) begin
            win = -1;
            if (m_pend[2] && !rn[2]) win = 2;
            else if (m_pend[0] && !rn[0] && m_pend[1] && !rn[1]) win = m_rr ? 1 : 0;
            else if (m_pend[0] && !rn[0]) win = 0;
            else if (m_pend[1] && !rn[1]) win = 1;
            if (win >= 0) begin
                m_cur = win; m_cur_wr = m_wr[win];
                e_mem_addr = m_addr[win]; e_mem_din = m_data[win];
                e_mem_rd = !m_wr[win]; e_mem_wr = m_wr[win];
                m_busy = 1'b1; m_wait_start = cyc + 2;
                if (win < 2) m_rr = (win == 0);
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (srd[p] || swr[p]) begin
                if (m_pend[p] && !rn[p]) begin
                    e_ovr = 1'b1;
                end else begin
                    m_pend[p] = 1'b1; m_addr[p] = sa[p]; m_data[p] = sd[p]; m_wr[p] = swr[p];
                end
            end else if (rn[p]) begin
                m_pend[p] = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk("mem_rd",   32'(mem_rd),   32'(e_mem_rd));
        chk("mem_wr",   32'(mem_wr),   32'(e_mem_wr));
        chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
        chk("mem_din",  32'(mem_din),  32'(e_mem_din));
        chk("s0_ready", 32'(s0_ready), 32'(e_rdy[0]));
        chk("s1_ready", 32'(s1_ready), 32'(e_rdy[1]));
        chk("ld_ack",   32'(ld_ack),   32'(e_rdy[2]));
        chk("s0_dout",  32'(s0_dout),  32'(e_dout[0]));
        chk("s1_dout",  32'(s1_dout),  32'(e_dout[1]));
        chk("overrun",  32'(overrun),  32'(e_ovr));
        chk("timeout",  32'(timeout),  32'(e_to));
        chk("one_ready", 32'((32'(s0_ready) + 32'(s1_ready) + 32'(ld_ack)) <= 32'd1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        cyc++;
        compare();
        if (mem_rd || mem_wr) begin
            cmd_addr.push_back(mem_addr); cmd_din.push_back(mem_din);
            cmd_wr.push_back(mem_wr);     cmd_cyc.push_back(cyc);
        end
        if (s0_ready) begin rdy_cnt[0]++; rdy_cyc[0] = cyc; end
        if (s1_ready) begin rdy_cnt[1]++; rdy_cyc[1] = cyc; end
        if (ld_ack)   begin rdy_cnt[2]++; rdy_cyc[2] = cyc; end
        mem_ready = 1'b0;
        mem_dout  = 8'h33;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_ready = 1'b1;
                mem_dout  = mem_val(resp_addr);
            end
        end
        if ((mem_rd || mem_wr) && resp_en) begin
            resp_cnt  = lat;
            resp_addr = mem_addr;
        end
        s0_rd = 1'b0; s0_wr = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0; ld_wr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        cmd_addr.delete(); cmd_din.delete(); cmd_wr.delete(); cmd_cyc.delete();
        for (int p = 0; p < 3; p++) begin rdy_cnt[p] = 0; rdy_cyc[p] = 0; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(1);
        clear_log();
    endtask

    int t0;

    initial begin
        clear_log();
        do_reset();
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_s0_dout", 32'(s0_dout), 32'd0);

        // single read
        lat = 2;
        s0_addr = 25'h0004000; s0_rd = 1'b1; t0 = cyc;
        run(12);
        chk("t1_cmds",    32'(cmd_addr.size()), 32'd1);
        chk("t1_addr",    32'(cmd_addr[0]), 32'h0004000);
        chk("t1_is_rd",   32'(cmd_wr[0]), 32'd0);
        chk("t1_dout",    32'(s0_dout), 32'h5A);
        chk("t1_s0_rdy",  32'(rdy_cnt[0]), 32'd1);
        chk("t1_s1_rdy",  32'(rdy_cnt[1]), 32'd0);
        chk("t1_ld_ack",  32'(rdy_cnt[2]), 32'd0);
        chk("t1_latency", 32'(rdy_cyc[0] - t0), 32'd5);

        // round-robin between slots
        do_reset();
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            s0_addr = 25'h0000100 + 25'(i); s0_rd = 1'b1;
            s1_addr = 25'h0000200 + 25'(i); s1_rd = 1'b1;
            run(10);
        end
        chk("t2_cmds", 32'(cmd_addr.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_s0", 32'(cmd_addr[2*i]),   32'h100 + 32'(i));
            chk("t2_order_s1", 32'(cmd_addr[2*i+1]), 32'h200 + 32'(i));
        end
        chk("t2_s0_rdy", 32'(rdy_cnt[0]), 32'd4);
        chk("t2_s1_rdy", 32'(rdy_cnt[1]), 32'd4);

        // loader priority
        do_reset();
        lat = 2;
        ld_addr = 25'h0010000; ld_data = 8'hC3; ld_wr = 1'b1;
        s1_addr = 25'h0000300; s1_rd = 1'b1;
        run(14);
        chk("t3_cmds",     32'(cmd_addr.size()), 32'd2);
        chk("t3_first_wr", 32'(cmd_wr[0]), 32'd1);
        chk("t3_ld_addr",  32'(cmd_addr[0]), 32'h0010000);
        chk("t3_ld_din",   32'(cmd_din[0]), 32'hC3);
        chk("t3_second_rd", 32'(cmd_wr[1]), 32'd0);
        chk("t3_s1_addr",  32'(cmd_addr[1]), 32'h300);
        chk("t3_ld_ack",   32'(rdy_cnt[2]), 32'd1);
        chk("t3_ack_first", 32'(rdy_cyc[2] < cmd_cyc[1]), 32'd1);
        chk("t3_s1_dout",  32'(s1_dout), 32'h19);

        // overrun
        do_reset();
        lat = 3;
        s0_addr = 25'h0000400; s0_rd = 1'b1;
        run(2);
        s0_addr = 25'h0000500; s0_rd = 1'b1;
        run(14);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_cmds",    32'(cmd_addr.size()), 32'd1);
        chk("t4_addr",    32'(cmd_addr[0]), 32'h400);
        chk("t4_s0_rdy",  32'(rdy_cnt[0]), 32'd1);
        chk("t4_dout",    32'(s0_dout), 32'h1E);

        // strobe in the same cycle as the ready pulse
        do_reset();
        lat = 1;
        s0_addr = 25'h0000010; s0_rd = 1'b1;
        run(4);
        s0_addr = 25'h0000020; s0_rd = 1'b1;
        run(10);
        chk("t7_cmds",    32'(cmd_addr.size()), 32'd2);
        chk("t7_addr2",   32'(cmd_addr[1]), 32'h20);
        chk("t7_s0_rdy",  32'(rdy_cnt[0]), 32'd2);
        chk("t7_overrun", 32'(overrun), 32'd0);
        chk("t7_dout",    32'(s0_dout), 32'h3A);

        // timeout, then normal service
        do_reset();
        resp_en = 1'b0;
        s1_addr = 25'h0000600; s1_rd = 1'b1;
        run(TIMEOUT + 10);
        chk("t5_s1_dout", 32'(s1_dout), 32'hFF);
        chk("t5_timeout", 32'(timeout), 32'd1);
        chk("t5_s1_rdy",  32'(rdy_cnt[1]), 32'd1);
        chk("t5_wait",    32'(rdy_cyc[1] - cmd_cyc[0]), 32'(TIMEOUT + 1));
        clear_log();
        resp_en = 1'b1;
        lat = 2;
        s0_addr = 25'h0004000; s0_rd = 1'b1;
        run(12);
        chk("t5_s0_dout", 32'(s0_dout), 32'h5A);
        chk("t5_s0_rdy",  32'(rdy_cnt[0]), 32'd1);
        chk("t5_sticky",  32'(timeout), 32'd1);

        // reset in the middle of a wait
        do_reset();
        lat = 4;
        s0_addr = 25'h0000700; s0_rd = 1'b1;
        run(3);
        reset = 1'b1;
        run(1);
        chk("t6_s0_ready", 32'(s0_ready), 32'd0);
        chk("t6_mem_addr", 32'(mem_addr), 32'd0);
        chk("t6_mem_rd",   32'(mem_rd), 32'd0);
        reset = 1'b0;
        clear_log();
        run(10);
        chk("t6_no_s0_rdy", 32'(rdy_cnt[0]), 32'd0);
        chk("t6_no_cmds",   32'(cmd_addr.size()), 32'd0);
        chk("t6_s0_dout",   32'(s0_dout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
